// File: rtl/level_sensor_filter_pkg.sv
// Shared level-code definitions for the reservoir level path.
// Used by the sensor filter and the flow controller.
// Optional feature macro used elsewhere in this slice: LEVEL_FAULT_CNT_EN.
package level_pkg;

  localparam int unsigned NUM_SENSORS = 3;

  typedef logic [NUM_SENSORS-1:0] level_t;

  // Thermometer codes, bit0 = lowest float switch
  localparam level_t LVL_EMPTY = 3'b000;
  localparam level_t LVL_LOW   = 3'b001;
  localparam level_t LVL_MID   = 3'b011;
  localparam level_t LVL_FULL  = 3'b111;

  function automatic logic is_legal_level(input level_t code);
    logic legal;
    case (code)
      LVL_EMPTY, LVL_LOW, LVL_MID, LVL_FULL: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/level_sensor_filter_if.sv
// Sensor-side bundle of the level filter: raw switch inputs in, clean level out.
// LEVEL_FAULT_CNT_EN adds the fault_cnt episode counter to the bundle.
interface level_sensor_filter_if;
  import level_pkg::*;

  level_t     raw_s;
  level_t     s;
  logic       s_chg;
  logic       fault;
`ifdef LEVEL_FAULT_CNT_EN
  logic [7:0] fault_cnt;

  modport master (output raw_s, input s, s_chg, fault, fault_cnt);
  modport slave  (input raw_s, output s, s_chg, fault, fault_cnt);
`else
  modport master (output raw_s, input s, s_chg, fault);
  modport slave  (input raw_s, output s, s_chg, fault);
`endif

endinterface

// File: rtl/level_sensor_filter_sensor_debounce.sv
// One float-switch channel: 2-flop synchroniser followed by a counting debouncer.
// The accepted value only flips after DEBOUNCE_CYCLES consecutive differing samples.
// Unaffected by LEVEL_FAULT_CNT_EN.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bring the asynchronous switch level into the clk domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Any sample agreeing with the accepted value restarts the count
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CntLast) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/level_sensor_filter.sv
// Level sensor filter: debounces the three float switches independently, then only
// forwards legal thermometer codes; illegal debounced patterns hold s and raise fault.
// LEVEL_FAULT_CNT_EN adds fault_cnt, a saturating count of fault rising edges.
module level_sensor_filter
  import level_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  level_sensor_filter_if.slave bus
);

  level_t deb;
  level_t s_q, s_d;
  logic   s_chg_q, s_chg_d;
  logic   fault_q, fault_d;

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_chan
    sensor_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.raw_s[i]),
      .deb   (deb[i])
    );
  end

  // Validate the debounced vector; an illegal code never reaches s
  always_comb begin
    s_d     = s_q;
    s_chg_d = 1'b0;
    fault_d = 1'b0;
    if (!is_legal_level(deb)) begin
      fault_d = 1'b1;
    end else if (deb != s_q) begin
      s_d     = deb;
      s_chg_d = 1'b1;
    end
  end

  // Output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q     <= LVL_EMPTY;
      s_chg_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      s_chg_q <= s_chg_d;
      fault_q <= fault_d;
    end
  end

  assign bus.s     = s_q;
  assign bus.s_chg = s_chg_q;
  assign bus.fault = fault_q;

`ifdef LEVEL_FAULT_CNT_EN
  logic [7:0] fault_cnt_q;

  // Count fault episodes (0->1 of the registered flag), saturating at 255
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_cnt_q <= '0;
    end else if (fault_d && !fault_q && (fault_cnt_q != 8'hff)) begin
      fault_cnt_q <= fault_cnt_q + 8'd1;
    end
  end

  assign bus.fault_cnt = fault_cnt_q;
`endif

endmodule

// File: doc/level_sensor_filter.md
Name: level_sensor_filter

Overview:
Upstream conditioning stage for the reservoir flow controller. It synchronises and debounces the three raw float-switch inputs, then validates them as a thermometer code. Only clean, legal level codes reach the controller's s[2:0] input; illegal patterns are held off and flagged as a fault.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised samples a bit must differ from its accepted value before it flips (legal range 1..255)
CNT_W, 8, width of each per-bit debounce counter (must hold DEBOUNCE_CYCLES-1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
raw_s  input  3  raw sensor levels, asynchronous to clk; bit0 = lowest switch
s  output  3  filtered legal level code, wired to the flow controller's s input
s_chg  output  1  one-cycle pulse when s takes a new value
fault  output  1  high while the debounced vector is an illegal code

Behaviour:
- Reset (reset=0, asynchronous): synchronisers, debounced bits, counters = 0; s=3'b000; s_chg=0; fault=0. Release is sampled on the next rising edge; no glitch on outputs.
- Synchronise: each raw_s bit passes through a 2-flop synchroniser (sync1, sync2).
- Debounce, per bit: if sync2 == deb, cnt <= 0. Otherwise, if cnt == DEBOUNCE_CYCLES-1, then deb <= sync2 and cnt <= 0; else cnt <= cnt+1. Any sample that matches deb restarts the count. Pulses shorter than DEBOUNCE_CYCLES samples never reach deb.
- Validate: the legal codes are 000, 001, 011, 111. On each edge:
  - deb legal and != s: s <= deb, s_chg <= 1, fault <= 0.
  - deb legal and == s: s holds, s_chg <= 0, fault <= 0.
  - deb illegal: s holds its last legal value, s_chg <= 0, fault <= 1.
- Latency: a raw change held stable reaches s after exactly DEBOUNCE_CYCLES+3 rising edges: 2 for synchronisation, DEBOUNCE_CYCLES for debounce, 1 for the output register. This is 7 edges at the default.
- Simultaneous bit changes: each bit debounces independently. A multi-bit step may pass through an illegal intermediate code, which raises fault for those cycles and is never emitted on s.
- Non-adjacent jumps between legal codes (for example 011 -> 000) are passed through as-is. Step limiting belongs to the controller.
- A reset mid-debounce discards all partial counts.
- DEBOUNCE_CYCLES=1: a bit flips on its first differing synchronised sample.

Optional Feature:
Macro: LEVEL_FAULT_CNT_EN.
- Defined: adds output fault_cnt [7:0]. It counts rising edges of fault (0->1 transitions), saturates at 255, and is cleared only by reset.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package level_pkg holds:
  - NUM_SENSORS = 3
  - level code constants LVL_EMPTY=3'b000, LVL_LOW=3'b001, LVL_MID=3'b011, LVL_FULL=3'b111
  - a function is_legal_level(3-bit)
  The flow controller shares these constants.
- Sub-module sensor_debounce: one bit, containing the synchroniser plus counter, with parameters DEBOUNCE_CYCLES and CNT_W. It is instantiated NUM_SENSORS times. Validation and the output register stay in the top module.

Test Plan:
1. Reset: reset=0 with raw_s=111 for 3 cycles, then release -> s=000, s_chg=0, fault=0 during reset. s=111 on the 7th edge after release, with a single s_chg pulse.
2. Step sequence 000 -> 001 -> 011 -> 111 -> 011 -> 000, each held 10 cycles (D=4) -> s follows each value 7 edges after the change, with one s_chg pulse per step and fault=0 throughout.
3. Glitch: s=001 settled, raw_s bit1 pulsed high for 3 cycles -> s stays 001, s_chg never pulses, fault=0. The same pulse held 4 cycles -> s=011 after 7 edges.
4. Illegal code: s=011 settled, raw_s=101 held 10 cycles -> fault=1 from the 7th edge onward while s holds 011. Returning raw_s to 111 -> fault=0 and s=111 after 7 edges.
5. Mid-operation reset: raw_s 000 -> 111, reset asserted for 1 cycle at edge 4 -> s=000 immediately. After release, s=111 a full 7 edges later, with no early update.
6. LEVEL_FAULT_CNT_EN: three separate illegal episodes of 101 (10 cycles each, separated by legal 111) -> fault_cnt=3. 300 episodes -> fault_cnt=255 (saturates).
